// File: rtl/fifo_ctrl_pkg.sv
// Shared types and helpers for the FIFO write-side control logic.
package fifo_ctrl_pkg;

  typedef enum logic {ARB = 1'b0, BURST = 1'b1} wr_arb_state_t;

  // Index width that never collapses to zero bits, even for a single entry.
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_pick
  import fifo_ctrl_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]              req,
  input  logic [clog2_min1(NREQ)-1:0]  ptr,
  output logic [clog2_min1(NREQ)-1:0]  gnt_idx,
  output logic                         any_req
);

  localparam int IW = clog2_min1(NREQ);

  logic [2*NREQ-1:0] w_dbl;
  logic [NREQ-1:0]   w_rot;
  logic [IW:0]       w_off;
  logic [IW:0]       w_sum;

  // Rotating the doubled vector puts requester ptr at bit 0.
  assign w_dbl   = {req, req} >> ptr;
  assign w_rot   = w_dbl[NREQ-1:0];
  assign any_req = |req;

  always_comb begin
    w_off = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (w_rot[i]) w_off = (IW+1)'(i);
    end
    w_sum = w_off + {1'b0, ptr};
    if (w_sum >= (IW+1)'(NREQ)) w_sum = w_sum - (IW+1)'(NREQ);
    gnt_idx = w_sum[IW-1:0];
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-locking arbiter sharing one async-FIFO write port among
// NREQ valid/ready requesters; never writes while the FIFO reports full.
module fifo_wr_arbiter
  import fifo_ctrl_pkg::*;
#(
  parameter int DSIZE     = 8,
  parameter int NREQ      = 4,
  parameter int MAX_BURST = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NREQ-1:0]              req_valid,
  input  logic [NREQ*DSIZE-1:0]        req_data,
  output logic [NREQ-1:0]              req_ready,
  output logic [DSIZE-1:0]             fifo_wdata,
  output logic                         fifo_winc,
  input  logic                         fifo_wfull,
  output logic [clog2_min1(NREQ)-1:0]  grant_id,
  output logic                         busy
);

  localparam int IW = clog2_min1(NREQ);
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [BW-1:0] LAST_BEAT = BW'(MAX_BURST - 1);
  localparam logic [IW-1:0] LAST_REQ  = IW'(NREQ - 1);

  wr_arb_state_t r_state;
  wr_arb_state_t w_next_state;
  logic [IW-1:0] r_grant;
  logic [IW-1:0] r_rr_ptr;
  logic [BW-1:0] r_beat_cnt;

  logic [IW-1:0]    w_pick;
  logic             w_any;
  logic             w_accept;
  logic             w_leave;
  logic [NREQ-1:0]  w_ready;
  logic [DSIZE-1:0] w_wdata;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req     (req_valid),
    .ptr     (r_rr_ptr),
    .gnt_idx (w_pick),
    .any_req (w_any)
  );

  // Handshake: a beat moves only when req_valid[i] && req_ready[i]; the
  // requester holds req_data stable while valid && !ready.
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_leave      = 1'b0;
    w_ready      = '0;
    w_wdata      = '0;
    case (r_state)
      ARB: begin
        if (w_any) w_next_state = BURST;
      end
      BURST: begin
        w_accept          = req_valid[r_grant] & ~fifo_wfull;
        w_ready[r_grant]  = w_accept;
        w_wdata           = req_data[r_grant*DSIZE +: DSIZE];
        // A full FIFO with valid still high stalls without releasing the lock.
        w_leave = (w_accept && (r_beat_cnt == LAST_BEAT)) || !req_valid[r_grant];
        if (w_leave) w_next_state = ARB;
      end
      default: w_next_state = ARB;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ARB;
      r_grant    <= '0;
      r_rr_ptr   <= '0;
      r_beat_cnt <= '0;
    end else begin
      r_state <= w_next_state;
      if (r_state == ARB) begin
        if (w_any) begin
          r_grant    <= w_pick;
          r_beat_cnt <= '0;
        end
      end else begin
        if (w_accept) r_beat_cnt <= r_beat_cnt + 1'b1;
        if (w_leave) r_rr_ptr <= (r_grant == LAST_REQ) ? '0 : r_grant + 1'b1;
      end
    end
  end

  assign req_ready  = w_ready;
  assign fifo_winc  = w_accept;
  assign fifo_wdata = w_wdata;
  assign grant_id   = r_grant;
  assign busy       = (r_state == BURST);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: vector table plus multi-cycle sequences.
module tb_fifo_wr_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  req_ready;
  logic [7:0]  fifo_wdata;
  logic        fifo_winc;
  logic        fifo_wfull = 1'b0;
  logic [1:0]  grant_id;
  logic        busy;

  logic [2:0]  v3 = '0;
  logic [23:0] d3 = '0;
  logic [2:0]  rdy3;
  logic [7:0]  wd3;
  logic        winc3;
  logic [1:0]  gid3;
  logic        busy3;

  int n_cmp  = 0;
  int n_fail = 0;

  fifo_wr_arbiter #(.DSIZE(8), .NREQ(4), .MAX_BURST(4)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .fifo_wdata(fifo_wdata), .fifo_winc(fifo_winc),
    .fifo_wfull(fifo_wfull), .grant_id(grant_id), .busy(busy)
  );

  fifo_wr_arbiter #(.DSIZE(8), .NREQ(3), .MAX_BURST(4)) dut3 (
    .clk(clk), .rst_n(rst_n), .req_valid(v3), .req_data(d3),
    .req_ready(rdy3), .fifo_wdata(wd3), .fifo_winc(winc3),
    .fifo_wfull(1'b0), .grant_id(gid3), .busy(busy3)
  );

  // Clock / reset
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  valid;
    logic [31:0] data;
    logic        wfull;
    logic        e_winc;
    logic [3:0]  e_ready;
    logic [7:0]  e_wdata;
    logic        e_busy;
    logic [1:0]  e_grant;
    logic [1:0]  e_ptr;
  } vec_t;

  vec_t tv [18];

  logic [7:0] exp_q [$];
  logic [7:0] fifo_q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req_valid = '0; req_data = '0; fifo_wfull = 1'b0; v3 = '0; d3 = '0;
    #2;
    chk("rst_winc", 32'(fifo_winc), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_wdata", 32'(fifo_wdata), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_grant", 32'(grant_id), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    // T1: single requester, 3 beats then drop
    tv[0]  = '{4'b0001, 32'h000000A1, 1'b0, 1'b0, 4'b0000, 8'h00, 1'b0, 2'd0, 2'd0};
    tv[1]  = '{4'b0001, 32'h000000A1, 1'b0, 1'b1, 4'b0001, 8'hA1, 1'b1, 2'd0, 2'd0};
    tv[2]  = '{4'b0001, 32'h000000A2, 1'b0, 1'b1, 4'b0001, 8'hA2, 1'b1, 2'd0, 2'd0};
    tv[3]  = '{4'b0001, 32'h000000A3, 1'b0, 1'b1, 4'b0001, 8'hA3, 1'b1, 2'd0, 2'd0};
    tv[4]  = '{4'b0000, 32'h000000A3, 1'b0, 1'b0, 4'b0000, 8'hA3, 1'b1, 2'd0, 2'd0};
    tv[5]  = '{4'b0000, 32'h000000A3, 1'b0, 1'b0, 4'b0000, 8'h00, 1'b0, 2'd0, 2'd1};
    // T6: valid drop while full
    tv[6]  = '{4'b0010, 32'h00005B00, 1'b0, 1'b0, 4'b0000, 8'h00, 1'b0, 2'd0, 2'd1};
    tv[7]  = '{4'b0010, 32'h00005B00, 1'b1, 1'b0, 4'b0000, 8'h5B, 1'b1, 2'd1, 2'd1};
    tv[8]  = '{4'b0000, 32'h00005B00, 1'b1, 1'b0, 4'b0000, 8'h5B, 1'b1, 2'd1, 2'd1};
    tv[9]  = '{4'b0000, 32'h00005B00, 1'b0, 1'b0, 4'b0000, 8'h00, 1'b0, 2'd1, 2'd2};
    // MAX_BURST exit, other requester ignored, valid drop at the final edge
    tv[10] = '{4'b1001, 32'h3C00000C, 1'b0, 1'b0, 4'b0000, 8'h00, 1'b0, 2'd1, 2'd2};
    tv[11] = '{4'b1001, 32'h3C00000C, 1'b0, 1'b1, 4'b1000, 8'h3C, 1'b1, 2'd3, 2'd2};
    tv[12] = '{4'b1001, 32'h3C00000C, 1'b0, 1'b1, 4'b1000, 8'h3C, 1'b1, 2'd3, 2'd2};
    tv[13] = '{4'b1001, 32'h3C00000C, 1'b0, 1'b1, 4'b1000, 8'h3C, 1'b1, 2'd3, 2'd2};
    tv[14] = '{4'b1001, 32'h3C00000C, 1'b0, 1'b1, 4'b1000, 8'h3C, 1'b1, 2'd3, 2'd2};
    tv[15] = '{4'b0001, 32'h3C00000C, 1'b0, 1'b0, 4'b0000, 8'h00, 1'b0, 2'd3, 2'd0};
    tv[16] = '{4'b0001, 32'h3C00000C, 1'b0, 1'b1, 4'b0001, 8'h0C, 1'b1, 2'd0, 2'd0};
    tv[17] = '{4'b0000, 32'h3C00000C, 1'b0, 1'b0, 4'b0000, 8'h0C, 1'b1, 2'd0, 2'd0};

    do_reset();
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      req_valid = tv[i].valid; req_data = tv[i].data; fifo_wfull = tv[i].wfull;
      #2;
      chk($sformatf("tv_winc[%0d]", i), 32'(fifo_winc), 32'(tv[i].e_winc));
      chk($sformatf("tv_ready[%0d]", i), 32'(req_ready), 32'(tv[i].e_ready));
      chk($sformatf("tv_wdata[%0d]", i), 32'(fifo_wdata), 32'(tv[i].e_wdata));
      chk($sformatf("tv_busy[%0d]", i), 32'(busy), 32'(tv[i].e_busy));
      chk($sformatf("tv_grant[%0d]", i), 32'(grant_id), 32'(tv[i].e_grant));
      chk($sformatf("tv_ptr[%0d]", i), 32'(dut.r_rr_ptr), 32'(tv[i].e_ptr));
    end
    @(negedge clk);
    req_valid = '0;
    #2;
    chk("tv_ptr_end", 32'(dut.r_rr_ptr), 32'd1);

    // T2: fairness with all requesters valid
    do_reset();
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      req_valid = 4'b1111; req_data = 32'h13121110; fifo_wfull = 1'b0;
      #2;
      if (c % 5 == 0) begin
        chk($sformatf("t2_arb_winc[%0d]", c), 32'(fifo_winc), 32'd0);
        chk($sformatf("t2_arb_busy[%0d]", c), 32'(busy), 32'd0);
      end else begin
        chk($sformatf("t2_winc[%0d]", c), 32'(fifo_winc), 32'd1);
        chk($sformatf("t2_grant[%0d]", c), 32'(grant_id), 32'((c / 5) % 4));
        chk($sformatf("t2_ready[%0d]", c), 32'(req_ready), 32'(1) << ((c / 5) % 4));
        chk($sformatf("t2_wdata[%0d]", c), 32'(fifo_wdata), 32'h10 + 32'((c / 5) % 4));
      end
    end

    // T3: req2 streams into a 16-deep FIFO drained every third cycle
    do_reset();
    begin
      logic [7:0] nxt;
      logic       full_r;
      logic       w;
      logic [7:0] wd;
      logic [7:0] got;
      logic [7:0] want;
      int         stalls;
      nxt = 8'h00; full_r = 1'b0; stalls = 0;
      for (int c = 0; c < 120; c++) begin
        @(negedge clk);
        req_valid = 4'b0100; req_data = {8'h00, nxt, 16'h0000}; fifo_wfull = full_r;
        #2;
        w = fifo_winc; wd = fifo_wdata;
        if (full_r) begin
          stalls++;
          chk($sformatf("t3_winc_full[%0d]", c), 32'(fifo_winc), 32'd0);
          chk($sformatf("t3_ready_full[%0d]", c), 32'(req_ready[2]), 32'd0);
        end
        if (busy) chk($sformatf("t3_grant[%0d]", c), 32'(grant_id), 32'd2);
        chk($sformatf("t3_ready_winc[%0d]", c), 32'(req_ready[2]), 32'(w));
        @(posedge clk);
        if (w) begin
          chk($sformatf("t3_no_overflow[%0d]", c), 32'(fifo_q.size() < 16), 32'd1);
          fifo_q.push_back(wd);
          exp_q.push_back(nxt);
          nxt = nxt + 8'd1;
        end
        if ((c % 3 == 0) && (fifo_q.size() > 0)) begin
          got = fifo_q.pop_front();
          want = exp_q.pop_front();
          chk($sformatf("t3_rd_order[%0d]", c), 32'(got), 32'(want));
        end
        full_r = (fifo_q.size() == 16);
      end
      chk("t3_saw_full", 32'(stalls > 0), 32'd1);
      fifo_q.delete();
      exp_q.delete();
    end

    // T5: reset during beat 2 of a burst
    do_reset();
    @(negedge clk);
    req_valid = 4'b0001; req_data = 32'h00000051;
    #2;
    chk("t5_arb", 32'(busy), 32'd0);
    @(negedge clk);
    #2;
    chk("t5_beat1", 32'(fifo_winc), 32'd1);
    @(negedge clk);
    req_data = 32'h00000052;
    #1;
    chk("t5_beat2_pre", 32'(fifo_winc), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_winc", 32'(fifo_winc), 32'd0);
    chk("t5_rst_ready", 32'(req_ready), 32'd0);
    chk("t5_rst_wdata", 32'(fifo_wdata), 32'd0);
    chk("t5_rst_busy", 32'(busy), 32'd0);
    chk("t5_rst_grant", 32'(grant_id), 32'd0);
    @(negedge clk);
    rst_n = 1'b1; req_valid = 4'b1010; req_data = 32'h77006600;
    #2;
    chk("t5_rel_busy", 32'(busy), 32'd0);
    chk("t5_rel_ptr", 32'(dut.r_rr_ptr), 32'd0);
    @(negedge clk);
    #2;
    chk("t5_first_grant", 32'(grant_id), 32'd1);
    chk("t5_first_winc", 32'(fifo_winc), 32'd1);
    chk("t5_first_wdata", 32'(fifo_wdata), 32'h66);

    // T4: NREQ=3 pointer wrap
    do_reset();
    @(negedge clk);
    v3 = 3'b100; d3 = 24'hC20000;
    #2;
    chk("t4_arb0", 32'(busy3), 32'd0);
    @(negedge clk);
    #2;
    chk("t4_grant2", 32'(gid3), 32'd2);
    chk("t4_winc2", 32'(winc3), 32'd1);
    chk("t4_wdata2", 32'(wd3), 32'hC2);
    chk("t4_ready2", 32'(rdy3), 32'b100);
    @(negedge clk);
    v3 = 3'b000;
    #2;
    chk("t4_drop_winc", 32'(winc3), 32'd0);
    @(negedge clk);
    v3 = 3'b001; d3 = 24'h0000C0;
    #2;
    chk("t4_ptr_wrap", 32'(dut3.r_rr_ptr), 32'd0);
    chk("t4_arb1", 32'(busy3), 32'd0);
    @(negedge clk);
    #2;
    chk("t4_grant0", 32'(gid3), 32'd0);
    chk("t4_winc0", 32'(winc3), 32'd1);
    chk("t4_wdata0", 32'(wd3), 32'hC0);
    @(negedge clk);
    v3 = 3'b000;
    @(negedge clk);
    #2;
    chk("t4_ptr_end", 32'(dut3.r_rr_ptr), 32'd1);
    chk("t4_idle", 32'(busy3), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
